// File: rtl/jpeg_transpose_pkg.sv
// rtl/jpeg_transpose_pkg.sv - shared types and sizing helpers for the ping-pong transpose buffer
//
// Purpose: bank state encoding, default block geometry and the counter-width
//          helper used by jpeg_transpose_pp and jpeg_transpose_bank.
// Contents:
//   bank_state_t  FREE (writable) / FULL (holds a complete block awaiting readout)
//   TP_N, TP_DW   default block dimension and element width
//   tp_cnt_w()    width of the row/column counters for a given N
package jpeg_transpose_pkg;

  typedef enum logic {
    BANK_FREE = 1'b0,
    BANK_FULL = 1'b1
  } bank_state_t;

  localparam int TP_N  = 8;
  localparam int TP_DW = 12;

  // Counters wrap by compare against N-1, so ceil(log2(N)) bits is enough
  // even when N is not a power of two.
  function automatic int tp_cnt_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/jpeg_transpose_bank.sv
// rtl/jpeg_transpose_bank.sv - one N x N element bank with row write and row/column read
//
// Purpose: stores one block of N rows of N elements. A whole row is written per
//          enabled clock; readout is combinational and returns either column
//          rd_idx (lane r = element(r, rd_idx)) or row rd_idx (lane k = element(rd_idx, k)).
// Ports:
//   clk      in   1      clock for the write port
//   we       in   1      write wr_row into row wr_idx on the rising edge
//   wr_idx   in   CW     row index being written
//   wr_row   in   N*DW   row data; lane k = column k
//   rd_idx   in   CW     column (rd_mode=1) or row (rd_mode=0) to read
//   rd_mode  in   1      1 = column readout, 0 = row readout
//   rd_vec   out  N*DW   selected column or row
module jpeg_transpose_bank
  import jpeg_transpose_pkg::*;
#(
  parameter int N  = TP_N,
  parameter int DW = TP_DW,
  localparam int CW = tp_cnt_w(N)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [CW-1:0]   wr_idx,
  input  logic [N*DW-1:0] wr_row,
  input  logic [CW-1:0]   rd_idx,
  input  logic            rd_mode,
  output logic [N*DW-1:0] rd_vec
);

  // Storage is deliberately not reset: bank state flags in the top decide
  // whether contents are meaningful.
  logic [DW-1:0] mem [N][N];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < N; k++) begin
        mem[wr_idx][k] <= wr_row[k*DW +: DW];
      end
    end
  end

  always_comb begin
    rd_vec = '0;
    for (int k = 0; k < N; k++) begin
      if (rd_mode) begin
        rd_vec[k*DW +: DW] = mem[k][rd_idx];
      end else begin
        rd_vec[k*DW +: DW] = mem[rd_idx][k];
      end
    end
  end

endmodule

// File: rtl/jpeg_transpose_pp.sv
// rtl/jpeg_transpose_pp.sv - N x N ping-pong transpose buffer between 1-D DCT passes
//
// Purpose: rows of a block are written into one bank while the previously
//          completed block is read out of the other bank, either as columns
//          (transposed) or as rows (straight), chosen per block by transpose_en
//          sampled with the block's first row.
// Ports:
//   clk           in   1      clock
//   rst_n         in   1      asynchronous active-low reset
//   in_valid      in   1      in_row valid
//   in_ready      out  1      current write bank is FREE
//   in_row        in   N*DW   row; lane k = column k
//   transpose_en  in   1      block mode, sampled with row 0 (1 = columns, 0 = rows)
//   out_valid     out  1      current read bank is FULL
//   out_ready     in   1      consumer accepts out_vec
//   out_vec       out  N*DW   column rcol (transposed) or row rcol (straight)
//   out_last      out  1      out_vec is the final vector of its block
//   bank_full     out  2      FULL flag per bank
module jpeg_transpose_pp
  import jpeg_transpose_pkg::*;
#(
  parameter int N  = TP_N,
  parameter int DW = TP_DW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*DW-1:0] in_row,
  input  logic            transpose_en,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N*DW-1:0] out_vec,
  output logic            out_last,
  output logic [1:0]      bank_full
);

  localparam int            CW       = tp_cnt_w(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  bank_state_t     bank_st [2];
  logic [1:0]      bank_mode;
  logic            wbank;
  logic            rbank;
  logic [CW-1:0]   wrow;
  logic [CW-1:0]   rcol;

  logic            wr_acc;
  logic            rd_acc;
  logic            wr_done;
  logic            rd_done;
  logic [N*DW-1:0] bank_vec [2];

  // Handshake flags decode registered state only, so neither ready depends
  // combinationally on the opposite side's valid/ready.
  assign in_ready  = (bank_st[wbank] == BANK_FREE);
  assign out_valid = (bank_st[rbank] == BANK_FULL);
  assign out_last  = out_valid && (rcol == CNT_LAST);
  assign out_vec   = bank_vec[rbank];
  assign bank_full = {bank_st[1] == BANK_FULL, bank_st[0] == BANK_FULL};

  assign wr_acc  = in_valid && in_ready;
  assign rd_acc  = out_valid && out_ready;
  assign wr_done = wr_acc && (wrow == CNT_LAST);
  assign rd_done = rd_acc && (rcol == CNT_LAST);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    localparam logic BSEL = 1'(b);

    // Both banks see the same read index; only the rbank output is used.
    jpeg_transpose_bank #(
      .N  (N),
      .DW (DW)
    ) u_bank (
      .clk     (clk),
      .we      (wr_acc && (wbank == BSEL)),
      .wr_idx  (wrow),
      .wr_row  (in_row),
      .rd_idx  (rcol),
      .rd_mode (bank_mode[b]),
      .rd_vec  (bank_vec[b])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_st[0] <= BANK_FREE;
      bank_st[1] <= BANK_FREE;
      bank_mode  <= '0;
      wbank      <= 1'b0;
      rbank      <= 1'b0;
      wrow       <= '0;
      rcol       <= '0;
    end else begin
      if (wr_acc) begin
        if (wrow == '0) begin
          bank_mode[wbank] <= transpose_en;
        end
        if (wrow == CNT_LAST) begin
          wrow  <= '0;
          wbank <= ~wbank;
        end else begin
          wrow <= wrow + CNT_ONE;
        end
      end

      if (rd_acc) begin
        if (rcol == CNT_LAST) begin
          rcol  <= '0;
          rbank <= ~rbank;
        end else begin
          rcol <= rcol + CNT_ONE;
        end
      end

      // A write can only complete on a FREE bank and a read only on a FULL
      // one, so the two updates never target the same bank in one cycle.
      for (int b = 0; b < 2; b++) begin
        if (wr_done && (wbank == 1'(b))) begin
          bank_st[b] <= BANK_FULL;
        end else if (rd_done && (rbank == 1'(b))) begin
          bank_st[b] <= BANK_FREE;
        end
      end
    end
  end

endmodule

// File: tb/tb_jpeg_transpose_pp.sv
// tb/tb_jpeg_transpose_pp.sv - scoreboard bench for jpeg_transpose_pp (N=8/DW=12 and N=4/DW=16)
module tb_jpeg_transpose_pp;
  import jpeg_transpose_pkg::*;

  localparam int N8  = 8;
  localparam int DW8 = 12;
  localparam int W8  = N8 * DW8;
  localparam int N4  = 4;
  localparam int DW4 = 16;
  localparam int W4  = N4 * DW4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          in_valid, in_ready, transpose_en, out_valid, out_ready, out_last;
  logic [W8-1:0] in_row, out_vec;
  logic [1:0]    bank_full;

  logic          in_valid4, in_ready4, transpose_en4, out_valid4, out_ready4, out_last4;
  logic [W4-1:0] in_row4, out_vec4;
  logic [1:0]    bank_full4;

  jpeg_transpose_pp #(.N(N8), .DW(DW8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
    .transpose_en(transpose_en), .out_valid(out_valid), .out_ready(out_ready),
    .out_vec(out_vec), .out_last(out_last), .bank_full(bank_full)
  );

  jpeg_transpose_pp #(.N(N4), .DW(DW4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4), .in_row(in_row4),
    .transpose_en(transpose_en4), .out_valid(out_valid4), .out_ready(out_ready4),
    .out_vec(out_vec4), .out_last(out_last4), .bank_full(bank_full4)
  );

  int             applied = 0;
  int             miscompares = 0;
  logic [W8:0]    exp_q[$];
  logic [W4:0]    q4[$];
  logic [DW8-1:0] m_blk [N8][N8];
  int             m_row;
  logic           m_mode;
  int             cyc = 0;
  logic           in_acc;
  logic [1:0]     acc_bf;
  int             out_cnt, first_out, last_out, stalls;
  int             seen01, seen10, seen11;

  // Reference model: capture accepted rows, and on block completion push the
  // N expected vectors (with last flag) in the order they must emerge.
  task automatic model_accept();
    logic [W8-1:0] e;
    if (m_row == 0) m_mode = transpose_en;
    for (int c = 0; c < N8; c++) m_blk[m_row][c] = in_row[c*DW8 +: DW8];
    m_row++;
    if (m_row == N8) begin
      for (int v = 0; v < N8; v++) begin
        for (int l = 0; l < N8; l++) e[l*DW8 +: DW8] = m_mode ? m_blk[l][v] : m_blk[v][l];
        exp_q.push_back({(v == N8 - 1), e});
      end
      m_row = 0;
    end
  endtask

  // One clock: sample at the falling edge, score any output handshake and
  // model any input handshake, then advance past the rising edge.
  task automatic cycle();
    logic [W8:0] e;
    @(negedge clk);
    if (out_valid && out_ready) begin
      if (out_cnt == 0) first_out = cyc;
      last_out = cyc;
      out_cnt++;
      applied++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_vec: got last=%b vec=%h, none expected", out_last, out_vec);
      end else begin
        e = exp_q.pop_front();
        if ({out_last, out_vec} !== e) begin
          miscompares++;
          $display("FAIL vec_%0d: got last=%b vec=%h, want last=%b vec=%h",
                   out_cnt - 1, out_last, out_vec, e[W8], e[W8-1:0]);
        end
      end
    end
    in_acc = in_valid && in_ready;
    if (in_acc) begin
      acc_bf = bank_full;
      model_accept();
    end
    if (bank_full == 2'b01) seen01++;
    if (bank_full == 2'b10) seen10++;
    if (bank_full == 2'b11) seen11++;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic send_row(input int base, input int r, input logic te);
    int waited;
    in_valid     = 1'b1;
    transpose_en = te;
    for (int c = 0; c < N8; c++) in_row[c*DW8 +: DW8] = DW8'(base + 16 * r + c);
    waited = 0;
    in_acc = 1'b0;
    while (!in_acc && waited < 64) begin
      cycle();
      if (!in_acc) waited++;
    end
    stalls += waited;
    if (!in_acc) begin
      applied++;
      miscompares++;
      $display("FAIL send_row_timeout: row %0d base %0d not accepted in 64 cycles", r, base);
    end
  endtask

  task automatic drain(input int bound);
    int k;
    in_valid = 1'b0;
    k = 0;
    while (exp_q.size() != 0 && k < bound) begin
      cycle();
      k++;
    end
    applied++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout: %0d vectors left, want 0", exp_q.size());
    end
  endtask

  task automatic apply_reset();
    in_valid = 1'b0; out_ready = 1'b0; transpose_en = 1'b0; in_row = '0;
    in_valid4 = 1'b0; out_ready4 = 1'b0; transpose_en4 = 1'b0; in_row4 = '0;
    rst_n = 1'b0;
    exp_q.delete();
    q4.delete();
    m_row = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    cyc++;
    #1;
    out_cnt = 0; stalls = 0; seen01 = 0; seen10 = 0; seen11 = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    applied++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    applied++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    applied++; if (out_last !== 1'b0) begin miscompares++; $display("FAIL reset_out_last: got %b want 0", out_last); end
    applied++; if (bank_full !== 2'b00) begin miscompares++; $display("FAIL reset_bank_full: got %b want 00", bank_full); end
    applied++; if (in_ready4 !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready4: got %b want 1", in_ready4); end
    applied++; if (bank_full4 !== 2'b00) begin miscompares++; $display("FAIL reset_bank_full4: got %b want 00", bank_full4); end
  endtask

  task automatic test_single_block();
    apply_reset();
    out_ready = 1'b1;
    for (int r = 0; r < N8; r++) begin
      send_row(0, r, 1'b1);
      if (r == N8 - 2) begin
        applied++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL latency_early: out_valid got %b want 0", out_valid); end
      end
    end
    applied++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL latency: out_valid got %b want 1", out_valid); end
    applied++; if (bank_full !== 2'b01) begin miscompares++; $display("FAIL single_bank_full: got %b want 01", bank_full); end
    drain(40);
    applied++; if (out_cnt !== N8) begin miscompares++; $display("FAIL single_count: got %0d want %0d", out_cnt, N8); end
  endtask

  task automatic test_back_to_back();
    int first_in;
    apply_reset();
    out_ready = 1'b1;
    first_in = 0;
    for (int b = 0; b < 3; b++) begin
      for (int r = 0; r < N8; r++) begin
        send_row(256 * b, r, 1'b1);
        if (b == 0 && r == 0) first_in = cyc - 1;
      end
    end
    drain(60);
    applied++; if (stalls !== 0) begin miscompares++; $display("FAIL b2b_stalls: got %0d want 0", stalls); end
    applied++; if (out_cnt !== 24) begin miscompares++; $display("FAIL b2b_count: got %0d want 24", out_cnt); end
    applied++; if (last_out - first_out !== 23) begin miscompares++; $display("FAIL b2b_span: got %0d want 23", last_out - first_out); end
    applied++; if (first_out - first_in !== 8) begin miscompares++; $display("FAIL b2b_first_out: got %0d want 8", first_out - first_in); end
    applied++; if (seen11 !== 0 || seen01 == 0 || seen10 == 0) begin
      miscompares++; $display("FAIL b2b_pingpong: got 01x%0d 10x%0d 11x%0d want 01>0 10>0 11=0", seen01, seen10, seen11);
    end
  endtask

  task automatic test_backpressure();
    logic [W8:0] e0;
    apply_reset();
    for (int i = 0; i < 16; i++) send_row(256 * (i / 8), i % 8, 1'b1);
    e0 = exp_q[0];
    in_valid = 1'b1;
    for (int c = 0; c < N8; c++) in_row[c*DW8 +: DW8] = DW8'(512 + c);
    for (int k = 0; k < 4; k++) begin
      cycle();
      applied++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready_%0d: got %b want 0", k, in_ready); end
      applied++; if (bank_full !== 2'b11) begin miscompares++; $display("FAIL bp_bank_full_%0d: got %b want 11", k, bank_full); end
      applied++; if (out_vec !== e0[W8-1:0]) begin miscompares++; $display("FAIL bp_hold_vec_%0d: got %h want %h", k, out_vec, e0[W8-1:0]); end
      applied++; if (out_last !== 1'b0) begin miscompares++; $display("FAIL bp_hold_last_%0d: got %b want 0", k, out_last); end
    end
    out_ready = 1'b1;
    for (int r = 0; r < 4; r++) begin
      send_row(512, r, 1'b1);
      if (r == 0) begin
        applied++; if (acc_bf !== 2'b10) begin miscompares++; $display("FAIL bp_resume_bank_full: got %b want 10", acc_bf); end
      end
    end
    drain(60);
    applied++; if (out_cnt !== 16) begin miscompares++; $display("FAIL bp_count: got %0d want 16", out_cnt); end
  endtask

  task automatic test_mode_switch();
    apply_reset();
    out_ready = 1'b1;
    for (int r = 0; r < N8; r++) send_row(0, r, (r == 0) ? 1'b1 : 1'(r % 2));
    for (int r = 0; r < N8; r++) send_row(256, r, (r == 0) ? 1'b0 : 1'((r + 1) % 2));
    drain(40);
    applied++; if (out_cnt !== 16) begin miscompares++; $display("FAIL mode_count: got %0d want 16", out_cnt); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    out_ready = 1'b1;
    for (int r = 0; r < N8; r++) send_row(0, r, 1'b1);
    for (int r = 0; r < 5; r++) send_row(256, r, 1'b1);
    applied++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL ar_reading: out_valid got %b want 1", out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    applied++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL ar_out_valid: got %b want 0", out_valid); end
    applied++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL ar_in_ready: got %b want 1", in_ready); end
    applied++; if (bank_full !== 2'b00) begin miscompares++; $display("FAIL ar_bank_full: got %b want 00", bank_full); end
    exp_q.delete();
    m_row = 0;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    cyc++;
    #1;
    out_cnt = 0;
    for (int r = 0; r < N8; r++) send_row(768, r, 1'b1);
    drain(40);
    applied++; if (out_cnt !== N8) begin miscompares++; $display("FAIL ar_after_count: got %0d want %0d", out_cnt, N8); end
  endtask

  task automatic test_n4();
    logic [W4-1:0] e;
    logic [W4:0]   got;
    logic [W4:0]   want;
    int            w;
    apply_reset();
    for (int b = 0; b < 2; b++) begin
      for (int r = 0; r < N4; r++) begin
        in_valid4 = 1'b1;
        transpose_en4 = (b == 0) ? ((r == 0) ? 1'b1 : 1'(r % 2)) : ((r == 0) ? 1'b0 : 1'b1);
        for (int c = 0; c < N4; c++) in_row4[c*DW4 +: DW4] = DW4'(4096 * b + 256 * r + c);
        @(negedge clk);
        applied++; if (in_ready4 !== 1'b1) begin miscompares++; $display("FAIL n4_in_ready_b%0d_r%0d: got %b want 1", b, r, in_ready4); end
        @(posedge clk);
        #1;
      end
      in_valid4 = 1'b0;
      for (int c = 0; c < N4; c++) begin
        for (int l = 0; l < N4; l++)
          e[l*DW4 +: DW4] = (b == 0) ? DW4'(256 * l + c) : DW4'(4096 + 256 * c + l);
        q4.push_back({(c == N4 - 1), e});
      end
      out_ready4 = 1'b1;
      for (int c = 0; c < N4; c++) begin
        w = 0;
        @(negedge clk);
        while (!out_valid4 && w < 20) begin
          @(negedge clk);
          w++;
        end
        applied++;
        if (!out_valid4) begin
          miscompares++; $display("FAIL n4_timeout_b%0d_v%0d: out_valid4 got 0 want 1", b, c);
        end else begin
          got  = {out_last4, out_vec4};
          want = q4.pop_front();
          if (got !== want) begin
            miscompares++;
            $display("FAIL n4_vec_b%0d_v%0d: got last=%b vec=%h, want last=%b vec=%h", b, c, got[W4], got[W4-1:0], want[W4], want[W4-1:0]);
          end
        end
        @(posedge clk);
        #1;
      end
      out_ready4 = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_back_to_back();
    test_backpressure();
    test_mode_switch();
    test_async_reset();
    test_n4();
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
